// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: FSM state
// encoding, the x0 register index and the default memory watchdog limit.
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID. Writes to x0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu
);

    logic hit_rs1;
    logic hit_rs2;

    // Per-operand match, then qualify with load and non-x0 destination
    always_comb begin
        hit_rs1 = id_use_rs1 && (ex_rd == id_rs1);
        hit_rs2 = id_use_rs2 && (ex_rd == id_rs2);
        lu      = ex_mem_read && (ex_rd != REG_X0) && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Produces per-stage
// write enables and flushes from load-use, branch and data-memory wait info,
// with a watchdog that parks the pipe in a sticky error state.
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int TMO_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        pc_redirect,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_we,
    output logic        id_ex_flush,
    output logic        ex_mem_we,
    output logic        mem_wb_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] memwait_cnt,
`endif
    output logic        mem_err
);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             lu;
    logic             ms;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    assign ms = mem_req && !mem_ready;

    // Next-state and watchdog counter; the counter saturates rather than wraps
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (ms) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TMO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + TMO_W'(1);
                    if (wait_cnt_q == CNT_LAST) state_d = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Output mux: reset forcing, then per-state control; in RUN the memory
    // freeze hides branch and load-use, and a branch flush hides load-use
    always_comb begin
        pc_we        = 1'b1;
        pc_redirect  = 1'b0;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_flush = 1'b0;
        mem_err      = 1'b0;
        if (reset) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state_q == ERR) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
            mem_err      = 1'b1;
        end else if (state_q == MEM_WAIT || ms) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (lu) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] memwait_cnt_q, memwait_cnt_d;
    logic        in_run;

    assign in_run = (state_q == RUN);

    // Event counters: each event qualified exactly as the output mux ranks it
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (in_run && !ms && !ex_branch_taken && lu && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (in_run && !ms && ex_branch_taken && flush_cnt_q != 32'hFFFF_FFFF)
            flush_cnt_d = flush_cnt_q + 32'd1;
        if (((in_run && ms) || state_q == MEM_WAIT) && memwait_cnt_q != 32'hFFFF_FFFF)
            memwait_cnt_d = memwait_cnt_q + 32'd1;
    end

    // Counter registers cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 16;

    // {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    //  ex_mem_we, mem_wb_flush, mem_err}
    localparam logic [8:0] O_DEF = 9'b1_0_1_0_1_0_1_0_0;
    localparam logic [8:0] O_RST = 9'b0_0_0_1_0_1_0_1_0;
    localparam logic [8:0] O_FRZ = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] O_LU  = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] O_BR  = 9'b1_1_1_1_1_1_1_0_0;
    localparam logic [8:0] O_ERR = 9'b0_0_0_0_0_0_0_1_1;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       use1, use2, mrd, br, mreq, mrdy;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic ex_mem_we, mem_wb_flush, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model: waiting flag, count of not-ready cycles, error flag
    bit m_wait, m_err;
    int m_miss;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_redirect(pc_redirect), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
        .mem_wb_flush(mem_wb_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
`endif
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    wire [8:0] dut_o = {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                        ex_mem_we, mem_wb_flush, mem_err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for this cycle from the spec rules, then advance the model
    task automatic model_step(input in_t v, output logic [8:0] e);
        bit lu, stall;
        lu = v.mrd && v.rd != 0 &&
             ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
        stall = v.mreq && !v.mrdy;
        if (v.rst) begin
            e = O_RST;
            m_wait = 0; m_err = 0; m_miss = 0;
        end else if (m_err) begin
            e = O_ERR;
        end else if (m_wait) begin
            e = O_FRZ;
            if (v.mrdy) begin
                m_wait = 0; m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss >= TMO) m_err = 1;
            end
        end else if (stall) begin
            e = O_FRZ;
            m_wait = 1; m_miss = 1;
        end else if (v.br) e = O_BR;
        else if (lu)      e = O_LU;
        else              e = O_DEF;
    endtask

    // Drive one cycle, compare against the model (and a fixed value if given)
    task automatic apply(input string name, input in_t v, input bit has_exp, input logic [8:0] exp);
        logic [8:0] me;
        @(posedge clk);
        #1;
        reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
        id_use_rs1 = v.use1; id_use_rs2 = v.use2; ex_mem_read = v.mrd;
        ex_branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
        #3;
        model_step(v, me);
        check({name, "/model"}, 32'(dut_o), 32'(me));
        if (has_exp) check(name, 32'(dut_o), 32'(exp));
    endtask

    function automatic in_t mk(bit rst, int rs1, int rs2, int rd, bit u1, bit u2,
                               bit mrd, bit br, bit mreq, bit mrdy);
        in_t v;
        v.rst = rst; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.use1 = u1; v.use2 = u2; v.mrd = mrd; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    vec_t tbl[$];
    in_t  idle, rst_v, lu_v, ms_v, rdy_v;

    initial begin
        reset = 1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu_v  = mk(0, 5, 0, 5, 1, 0, 1, 0, 0, 0);
        ms_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rdy_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        tbl.push_back('{"reset",        rst_v,                                O_RST});
        tbl.push_back('{"idle",         idle,                                 O_DEF});
        tbl.push_back('{"lu_rs1",       lu_v,                                 O_LU});
        tbl.push_back('{"lu_one_shot",  idle,                                 O_DEF});
        tbl.push_back('{"rd_x0",        mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0),     O_DEF});
        tbl.push_back('{"lu_rs2",       mk(0, 3, 9, 9, 0, 1, 1, 0, 0, 0),     O_LU});
        tbl.push_back('{"rs1_unused",   mk(0, 5, 0, 5, 0, 0, 1, 0, 0, 0),     O_DEF});
        tbl.push_back('{"not_load",     mk(0, 5, 5, 5, 1, 1, 0, 0, 0, 0),     O_DEF});
        tbl.push_back('{"branch_lu",    mk(0, 5, 0, 5, 1, 0, 1, 1, 0, 0),     O_BR});
        tbl.push_back('{"mem_ready_0w", rdy_v,                                O_DEF});
        tbl.push_back('{"rs2_mismatch", mk(0, 1, 2, 7, 1, 1, 1, 0, 0, 0),     O_DEF});

        foreach (tbl[k]) apply(tbl[k].name, tbl[k].i, 1, tbl[k].exp);

        // memory wait: ready arrives after 3 low cycles, branch held during wait
        apply("mw0", ms_v, 1, O_FRZ);
        apply("mw1_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, O_FRZ);
        apply("mw2_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1, O_FRZ);
        apply("mw3_rdy", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 1, O_FRZ);
        apply("mw4_br_run", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, O_BR);

        // watchdog: TMO not-ready cycles, then sticky error until reset
        for (int c = 0; c < TMO; c++) apply("tmo_wait", ms_v, 1, O_FRZ);
        apply("tmo_err", ms_v, 1, O_ERR);
        apply("tmo_err_sticky", rdy_v, 1, O_ERR);
        apply("tmo_err_idle", idle, 1, O_ERR);
        apply("tmo_reset", rst_v, 1, O_RST);
        apply("tmo_recover", idle, 1, O_DEF);

        // reset asserted mid-wait
        apply("rmw0", ms_v, 1, O_FRZ);
        apply("rmw1", ms_v, 1, O_FRZ);
        apply("rmw2_reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, O_RST);
        apply("rmw3_run", idle, 1, O_DEF);

`ifdef HAZARD_PERF_CNT_EN
        apply("pc_reset", rst_v, 1, O_RST);
        apply("pc_lu1", lu_v, 1, O_LU);
        apply("pc_idle", idle, 1, O_DEF);
        apply("pc_lu2", lu_v, 1, O_LU);
        apply("pc_br", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, O_BR);
        apply("pc_mw0", ms_v, 1, O_FRZ);
        apply("pc_mw1", ms_v, 1, O_FRZ);
        apply("pc_mw2", ms_v, 1, O_FRZ);
        apply("pc_mw3", rdy_v, 1, O_FRZ);
        apply("pc_end", idle, 1, O_DEF);
        check("stall_cnt", stall_cnt, 32'd2);
        check("flush_cnt", flush_cnt, 32'd1);
        check("memwait_cnt", memwait_cnt, 32'd4);
`endif

        // randomized run; ready probability alternates to reach the watchdog
        for (int c = 0; c < 4000; c++) begin
            in_t v;
            int  rdy_pct;
            rdy_pct = ((c / 300) % 2 == 0) ? 50 : 4;
            v.rst  = ($urandom_range(0, 99) < 2);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            v.use1 = 1'($urandom);
            v.use2 = 1'($urandom);
            v.mrd  = 1'($urandom);
            v.br   = ($urandom_range(0, 99) < 20);
            v.mreq = ($urandom_range(0, 99) < 25);
            v.mrdy = ($urandom_range(0, 99) < rdy_pct);
            apply("rand", v, 0, O_DEF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits, with a timeout watchdog on memory.
- Sits beside the datapath; consumes decode and EX/MEM stage info, produces per-stage control.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before error.
- TMO_W, 5: width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM-stage instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC update enable.
- pc_redirect  out  1  select branch target as next PC.
- if_id_we  out  1  IF_ID write enable.
- if_id_flush  out  1  IF_ID loads a bubble.
- id_ex_we  out  1  ID_EX write enable.
- id_ex_flush  out  1  ID_EX loads a bubble.
- ex_mem_we  out  1  EX_MEM write enable.
- mem_wb_flush  out  1  MEM_WB loads a bubble (RegWrite=0, MemtoReg=0).
- mem_err  out  1  sticky memory-timeout error.

Behaviour:
- State register, updated on posedge clk. States: RUN, MEM_WAIT, ERR.
- All outputs are combinational functions of state and inputs.
- Default output values in RUN: every *_we=1, every *_flush=0, pc_redirect=0, mem_err=0.
- Reset (sampled at posedge): state←RUN, wait counter←0.
  - While reset=1, outputs are forced: all *_we=0, all *_flush=1, pc_redirect=0, mem_err=0.
  - A reset during MEM_WAIT or ERR returns to RUN on the next edge.
- Load-use hazard (lu) = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- Memory stall (ms) = mem_req & ~mem_ready.
- Priority in RUN, highest first: ms > ex_branch_taken > lu.
  - ms: pc_we = if_id_we = id_ex_we = ex_mem_we = 0, mem_wb_flush=1. The branch and lu actions are suppressed this cycle and re-evaluated after the wait. Next state MEM_WAIT; counter←1.
  - ex_branch_taken: pc_redirect=1, if_id_flush=1, id_ex_flush=1. The flush supersedes any simultaneous lu. Stay in RUN.
  - lu: pc_we=0, if_id_we=0, id_ex_flush=1. Exactly one bubble per hazard. Stay in RUN.
- MEM_WAIT:
  - Outputs are as for ms, regardless of other inputs.
  - mem_ready=1 → next RUN, counter←0. The completing cycle still holds the freeze; the ready data are captured into MEM_WB on the first RUN edge.
  - Otherwise counter←counter+1. If counter==MEM_TIMEOUT-1 while not ready → next ERR.
- ERR:
  - mem_err=1, all *_we=0, mem_wb_flush=1; other flushes 0.
  - Stays in ERR until reset.
- Latency: control outputs act in the same cycle as the triggering input. A memory stall lasts N+1 frozen cycles when mem_ready arrives N cycles after the request.
- Counter saturates; it never wraps.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds 32-bit outputs stall_cnt, flush_cnt and memwait_cnt:
  - stall_cnt: +1 per lu cycle taken.
  - flush_cnt: +1 per branch flush.
  - memwait_cnt: +1 per cycle with ex_mem_we=0 due to memory.
  - All three clear on reset and saturate at 0xFFFF_FFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2;
  - the x0 register index constant;
  - the default MEM_TIMEOUT.
- One natural sub-module: hazard_detect, the purely combinational lu compare. The FSM, counter and output mux stay in the top module.

Test Plan:
- After reset release: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle → pc_we=0, if_id_we=0, id_ex_flush=1 for exactly that cycle; ex_rd=0 with the same stimulus → no stall.
- ex_branch_taken=1 together with the load-use pattern → pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_we=1 (branch wins).
- mem_req=1, mem_ready low for 3 cycles then high → all *_we=0 and mem_wb_flush=1 for 4 cycles; RUN resumes on the 5th; a branch asserted during the wait is not acted on until RUN.
- mem_req=1, mem_ready=0 held for MEM_TIMEOUT cycles → mem_err=1 and remains 1; reset pulse → mem_err=0, state RUN.
- Reset asserted mid-MEM_WAIT at cycle 2 → outputs forced to reset values that cycle; RUN defaults on the cycle after reset deasserts.
- With HAZARD_PERF_CNT_EN: 2 lu stalls, 1 branch flush, 3-cycle memory wait → stall_cnt=2, flush_cnt=1, memwait_cnt=4.
